// File: rtl/mem_pkg.sv
// mem_pkg: FSM state type, strobe width and address helpers used by dmem_responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // One strobe bit per byte of the 32-bit data word.
    localparam int STRB_W = 4;

    // Widest address the helpers handle; callers zero-extend into this width.
    localparam int MAX_ADDR_W = 64;

    // Word index of a byte address.
    function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

    // True when the byte address does not fall on a word boundary.
    function automatic logic is_misaligned(input logic [MAX_ADDR_W-1:0] addr);
        return (addr & MAX_ADDR_W'(3)) != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with byte-enable write port and registered read port.
// A read and a write to the same word in one cycle return the pre-write contents.
// The read register only changes when i_re is high, so it holds the last loaded word.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              i_re,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Storage update and read capture; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store target on valid/ready request and response channels,
// answering WAIT_CYCLES+1 cycles after acceptance.
// Optional performance counters: define DMEM_RESPONDER_PERF_CNT_EN.
// rst is asynchronous and active-low. ADDR_W must lie in 3..64.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_RESPONDER_PERF_CNT_EN
    ,
    output logic [31:0]       perf_loads,
    output logic [31:0]       perf_stores,
    output logic [31:0]       perf_errs
`endif
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;

    logic                  r_write;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_rd_sel;

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_rsp_hs;

    logic                  w_c_write;
    logic [ADDR_W-1:0]     w_c_addr;
    logic [DATA_W-1:0]     w_c_wdata;
    logic [STRB_W-1:0]     w_c_wstrb;
    logic [MAX_ADDR_W-1:0] w_addr_ext;
    logic [MAX_ADDR_W-1:0] w_widx;
    logic                  w_err;
    logic                  w_ram_re;
    logic                  w_ram_we;
    logic [DATA_W-1:0]     w_ram_rdata;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: accept in IDLE, count down in WAIT, drain in RESP.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE outside reset; commit on the edge that enters RESP.
    always_comb begin
        req_ready = 1'b0;
        w_commit  = 1'b0;
        w_rsp_hs  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = rst;
                w_commit  = (WAIT_CYCLES == 0) && req_valid && rst;
            end
            WAIT:    w_commit = (r_cnt == 4'd0);
            RESP:    w_rsp_hs = rsp_ready;
            default: ;
        endcase
    end

    assign w_accept = req_valid && req_ready;

    // Wait-state counter, loaded at acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == IDLE && w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Latch the accepted request; later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // With no wait states the commit edge is the acceptance edge, so use the live inputs.
    assign w_c_write  = (WAIT_CYCLES == 0) ? req_write : r_write;
    assign w_c_addr   = (WAIT_CYCLES == 0) ? req_addr  : r_addr;
    assign w_c_wdata  = (WAIT_CYCLES == 0) ? req_wdata : r_wdata;
    assign w_c_wstrb  = (WAIT_CYCLES == 0) ? req_wstrb : r_wstrb;

    assign w_addr_ext = MAX_ADDR_W'(w_c_addr);
    assign w_widx     = word_index(w_addr_ext);
    assign w_err      = is_misaligned(w_addr_ext) || (w_widx >= MAX_ADDR_W'(DEPTH_WORDS));
    assign w_ram_we   = w_commit && !w_err && w_c_write;
    assign w_ram_re   = w_commit && !w_err && !w_c_write;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_re    (w_ram_re),
        .i_we    (w_ram_we),
        .i_idx   (w_widx[IDX_W-1:0]),
        .i_wdata (w_c_wdata),
        .i_wstrb (w_c_wstrb),
        .o_rdata (w_ram_rdata)
    );

    // Response flags: set at commit, cleared by the response handshake.
    // r_rd_sel picks the RAM read register for good loads and zero otherwise;
    // it survives the handshake so rsp_rdata keeps its value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rd_sel    <= 1'b0;
        end else if (w_commit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rd_sel    <= w_ram_re;
        end else if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rd_sel ? w_ram_rdata : '0;

`ifdef DMEM_RESPONDER_PERF_CNT_EN
    logic [31:0] r_perf_loads;
    logic [31:0] r_perf_stores;
    logic [31:0] r_perf_errs;

    // Commit-edge event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_loads  <= 32'd0;
            r_perf_stores <= 32'd0;
            r_perf_errs   <= 32'd0;
        end else if (w_commit) begin
            if (w_err) begin
                r_perf_errs <= r_perf_errs + 32'd1;
            end else if (w_c_write) begin
                r_perf_stores <= r_perf_stores + 32'd1;
            end else begin
                r_perf_loads <= r_perf_loads + 32'd1;
            end
        end
    end

    assign perf_loads  = r_perf_loads;
    assign perf_stores = r_perf_stores;
    assign perf_errs   = r_perf_errs;
`else
    // Performance counters are compiled out of this build.
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a
// word-array reference model. u_dut uses two wait states, u_dut0 uses none.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        req_valid_z, req_ready_z, req_write_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
    logic [3:0]  req_wstrb_z;

`ifdef DMEM_RESPONDER_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
    logic [31:0] perf_loads_z, perf_stores_z, perf_errs_z;
`endif

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_RESPONDER_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_wstrb(req_wstrb_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
`ifdef DMEM_RESPONDER_PERF_CNT_EN
        , .perf_loads(perf_loads_z), .perf_stores(perf_stores_z), .perf_errs(perf_errs_z)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: storage words plus per-kind commit counts since the last reset.
    logic [31:0] model_mem [DEPTH];
    int m_loads = 0, m_stores = 0, m_errs = 0;

    function automatic bit addr_bad(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= DEPTH);
    endfunction

    task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output logic [31:0] exp_rd, output logic exp_err);
        exp_err = addr_bad(a);
        exp_rd  = 32'd0;
        if (exp_err) begin
            m_errs++;
        end else if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[a / 4][8*b +: 8] = d[8*b +: 8];
            m_stores++;
        end else begin
            exp_rd = model_mem[a / 4];
            m_loads++;
        end
    endtask

    // One request/response on u_dut. Called and returns at a falling edge.
    // Garbage is driven on the request pins while the request is in flight.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int bp, output logic [31:0] rd, output logic e, output int lat,
                        output logic v_after);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        n = 0;
        while (req_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        @(negedge clk);
        req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        req_valid = 1'b0;
        rd = rsp_rdata; e = rsp_err;
        rsp_ready = 1'b0;
        repeat (bp) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        v_after = rsp_valid;
        if (n >= 64 || lat >= 64) begin
            checks++; errors++;
            $display("FAIL xact_timeout: addr=%h accept_wait=%0d latency=%0d, required under 64", a, n, lat);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        m_loads = 0; m_stores = 0; m_errs = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        req_valid_z = 0; req_write_z = 0; req_addr_z = 0; req_wdata_z = 0; req_wstrb_z = 0; rsp_ready_z = 0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b, expected 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h, expected 0", rsp_rdata); end
        checks++; if (req_ready_z !== 1'b0) begin errors++; $display("FAIL reset_req_ready_w0: got %b, expected 0", req_ready_z); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b, expected 1", req_ready); end
`ifdef DMEM_RESPONDER_PERF_CNT_EN
        checks++; if (perf_errs !== 32'd0) begin errors++; $display("FAIL reset_perf_errs: got %0d, expected 0", perf_errs); end
`endif
    endtask

    task automatic test_store_load();
        logic [31:0] rd, exp_rd; logic e, exp_e, va; int lat;
        model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, exp_rd, exp_e);
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat, va);
        checks++; if (lat != WC + 1) begin errors++; $display("FAIL store_latency: got %0d, expected %0d", lat, WC + 1); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err: got %b, expected 0", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL store_rdata: got %h, expected 0", rd); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL store_valid_one_cycle: got %b, expected 0", va); end
        model_apply(1'b0, 32'h10, 32'd0, 4'h0, exp_rd, exp_e);
        xact(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, e, lat, va);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_after_store: got %h, expected deadbeef", rd); end
        checks++; if (lat != WC + 1) begin errors++; $display("FAIL load_latency: got %0d, expected %0d", lat, WC + 1); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd, exp_rd; logic e, exp_e, va; int lat;
        model_apply(1'b1, 32'h20, 32'h11223344, 4'hF, exp_rd, exp_e);
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, 1, rd, e, lat, va);
        model_apply(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, exp_rd, exp_e);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, e, lat, va);
        model_apply(1'b1, 32'h20, 32'h99999999, 4'h0, exp_rd, exp_e);
        xact(1'b1, 32'h20, 32'h99999999, 4'h0, 0, rd, e, lat, va);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL zero_strobe_err: got %b, expected 0", e); end
        model_apply(1'b0, 32'h20, 32'd0, 4'h0, exp_rd, exp_e);
        xact(1'b0, 32'h20, 32'd0, 4'h0, 0, rd, e, lat, va);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge: got %h, expected 11bb33dd", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, v, exp_rd, exp_rd2; logic e, exp_e, va; int lat, n;
        v = $urandom;
        model_apply(1'b1, 32'h30, v, 4'hF, exp_rd, exp_e);
        xact(1'b1, 32'h30, v, 4'hF, 0, rd, e, lat, va);
        model_apply(1'b0, 32'h30, 32'd0, 4'h0, exp_rd, exp_e);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30; rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        @(negedge clk);
        req_addr = 32'h20;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        checks++; if (lat != WC + 1) begin errors++; $display("FAIL bp_latency: got %0d, expected %0d", lat, WC + 1); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold[%0d]: got %b, expected 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL bp_rdata_hold[%0d]: got %h, expected %h", i, rsp_rdata, exp_rd); end
            checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_err_hold[%0d]: got %b, expected 0", i, rsp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b, expected 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_hs_valid: got %b, expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs_ready: got %b, expected 1", req_ready); end
        checks++; if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL bp_rdata_kept: got %h, expected %h", rsp_rdata, exp_rd); end
        model_apply(1'b0, 32'h20, 32'd0, 4'h0, exp_rd2, exp_e);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        checks++; if (lat != WC + 1) begin errors++; $display("FAIL bp_second_latency: got %0d, expected %0d", lat, WC + 1); end
        checks++; if (rsp_rdata !== exp_rd2) begin errors++; $display("FAIL bp_second_rdata: got %h, expected %h", rsp_rdata, exp_rd2); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] rd, v, exp_rd; logic e, exp_e, va; int lat;
        apply_reset();
        v = $urandom;
        model_apply(1'b1, 32'hFFC, v, 4'hF, exp_rd, exp_e);
        xact(1'b1, 32'hFFC, v, 4'hF, 0, rd, e, lat, va);
        model_apply(1'b0, 32'h13, 32'd0, 4'h0, exp_rd, exp_e);
        xact(1'b0, 32'h13, 32'd0, 4'h0, 0, rd, e, lat, va);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b, expected 1", e); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misaligned_rdata: got %h, expected 0", rd); end
        model_apply(1'b1, DEPTH * 4, ~v, 4'hF, exp_rd, exp_e);
        xact(1'b1, DEPTH * 4, ~v, 4'hF, 2, rd, e, lat, va);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_err: got %b, expected 1", e); end
        model_apply(1'b0, 32'hFFC, 32'd0, 4'h0, exp_rd, exp_e);
        xact(1'b0, 32'hFFC, 32'd0, 4'h0, 0, rd, e, lat, va);
        checks++; if (rd !== v) begin errors++; $display("FAIL last_word_unchanged: got %h, expected %h", rd, v); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b, expected 0", e); end
`ifdef DMEM_RESPONDER_PERF_CNT_EN
        checks++; if (perf_errs !== 32'd2) begin errors++; $display("FAIL perf_errs: got %0d, expected 2", perf_errs); end
        checks++; if (perf_loads !== 32'(m_loads)) begin errors++; $display("FAIL perf_loads_err_test: got %0d, expected %0d", perf_loads, m_loads); end
        checks++; if (perf_stores !== 32'(m_stores)) begin errors++; $display("FAIL perf_stores_err_test: got %0d, expected %0d", perf_stores, m_stores); end
`endif
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, p, exp_rd; logic e, exp_e, va; int lat, n;
        p = $urandom;
        model_apply(1'b1, 32'h40, p, 4'hF, exp_rd, exp_e);
        xact(1'b1, 32'h40, p, 4'hF, 0, rd, e, lat, va);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_wstrb = 4'hF;
        n = 0;
        while (req_ready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        @(negedge clk);
        rst = 1'b0;
        #1;
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", rsp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b, expected 0", req_ready); end
        repeat (3) @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp: got %b, expected 0", rsp_valid); end
        rst = 1'b1;
        m_loads = 0; m_stores = 0; m_errs = 0;
        @(negedge clk);
        model_apply(1'b0, 32'h40, 32'd0, 4'h0, exp_rd, exp_e);
        xact(1'b0, 32'h40, 32'd0, 4'h0, 0, rd, e, lat, va);
        checks++; if (rd !== p) begin errors++; $display("FAIL midreset_contents: got %h, expected %h", rd, p); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, a, d; logic e, exp_e, va, w; logic [3:0] s; int lat, bp, kind, word;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            word = (i < 8) ? i : (DEPTH - 16 + i);
            d = $urandom;
            model_apply(1'b1, 32'(word * 4), d, 4'hF, exp_rd, exp_e);
            xact(1'b1, 32'(word * 4), d, 4'hF, 0, rd, e, lat, va);
        end
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            word = $urandom_range(0, 15);
            word = (word < 8) ? word : (DEPTH - 16 + word);
            if (kind == 0)      a = 32'(word * 4) + 32'($urandom_range(1, 3));
            else if (kind == 1) a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
            else                a = 32'(word * 4);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom);
            bp = $urandom_range(0, 3);
            model_apply(w, a, d, s, exp_rd, exp_e);
            xact(w, a, d, s, bp, rd, e, lat, va);
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d] addr=%h w=%b: got %h, expected %h", i, a, w, rd, exp_rd); end
            checks++; if (e !== exp_e) begin errors++; $display("FAIL rand_err[%0d] addr=%h: got %b, expected %b", i, a, e, exp_e); end
            checks++; if (lat != WC + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, expected %0d", i, lat, WC + 1); end
            checks++; if (va !== 1'b0) begin errors++; $display("FAIL rand_valid_drop[%0d]: got %b, expected 0", i, va); end
        end
`ifdef DMEM_RESPONDER_PERF_CNT_EN
        checks++; if (perf_loads !== 32'(m_loads)) begin errors++; $display("FAIL rand_perf_loads: got %0d, expected %0d", perf_loads, m_loads); end
        checks++; if (perf_stores !== 32'(m_stores)) begin errors++; $display("FAIL rand_perf_stores: got %0d, expected %0d", perf_stores, m_stores); end
        checks++; if (perf_errs !== 32'(m_errs)) begin errors++; $display("FAIL rand_perf_errs: got %0d, expected %0d", perf_errs, m_errs); end
`endif
    endtask

    task automatic test_wait0();
        logic [31:0] v; int nvalid, nbad;
        v = $urandom;
        req_valid_z = 1'b1; req_write_z = 1'b1; req_addr_z = 32'h8; req_wdata_z = v; req_wstrb_z = 4'hF;
        rsp_ready_z = 1'b1;
        checks++; if (req_ready_z !== 1'b1) begin errors++; $display("FAIL w0_ready: got %b, expected 1", req_ready_z); end
        @(negedge clk);
        checks++; if (rsp_valid_z !== 1'b1) begin errors++; $display("FAIL w0_store_latency: got %b, expected 1", rsp_valid_z); end
        checks++; if (rsp_err_z !== 1'b0) begin errors++; $display("FAIL w0_store_err: got %b, expected 0", rsp_err_z); end
        checks++; if (req_ready_z !== 1'b0) begin errors++; $display("FAIL w0_resp_ready: got %b, expected 0", req_ready_z); end
        req_write_z = 1'b0; req_wdata_z = $urandom;
        @(negedge clk);
        checks++; if (rsp_valid_z !== 1'b0) begin errors++; $display("FAIL w0_after_hs_valid: got %b, expected 0", rsp_valid_z); end
        @(negedge clk);
        checks++; if (rsp_valid_z !== 1'b1) begin errors++; $display("FAIL w0_load_latency: got %b, expected 1", rsp_valid_z); end
        checks++; if (rsp_rdata_z !== v) begin errors++; $display("FAIL w0_load_rdata: got %h, expected %h", rsp_rdata_z, v); end
        nvalid = 0; nbad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_z === 1'b1) begin
                nvalid++;
                if (rsp_rdata_z !== v) nbad++;
            end
        end
        checks++; if (nvalid != 10) begin errors++; $display("FAIL w0_b2b_rate: got %0d responses, expected 10", nvalid); end
        checks++; if (nbad != 0) begin errors++; $display("FAIL w0_b2b_rdata: got %0d bad responses, expected 0", nbad); end
        req_valid_z = 1'b0;
        repeat (2) @(negedge clk);
        rsp_ready_z = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_strobes();
        test_backpressure();
        test_errors();
        test_reset_mid_wait();
        test_random();
        test_wait0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that answers the core's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Word-addressed storage, byte write strobes, and a configurable number of wait states.
- Sits between the core's memory-stage request logic and on-chip data RAM, replacing the zero-latency dmem so that multi-cycle and stalling memory paths can be exercised.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 32, data width in bits; fixed at 32, and the strobe width is DATA_W/8.
- DEPTH_WORDS, 1024, number of 32-bit storage words.
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- req_wstrb  input  4  byte enables for stores; ignored for loads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_W  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst=0, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - req_ready=0 while rst=0 (req_ready = state==IDLE && rst).
  - Storage contents are not reset.
- IDLE:
  - req_ready=1.
  - Handshake at edge E0 (req_valid && req_ready) latches write, addr, wdata and wstrb.
  - If WAIT_CYCLES=0, go to RESP at E0. Otherwise go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge; the edge at which counter==0 moves to RESP.
- Commit edge: the edge entering RESP is E0+WAIT_CYCLES. At that edge:
  - Error check: error if addr[1:0]!=0 or addr[ADDR_W-1:2] >= DEPTH_WORDS.
  - Error: no storage access; rsp_err=1, rsp_rdata=0.
  - Store: for each strobe bit i set, byte i of word addr[ADDR_W-1:2] := wdata byte i. rsp_rdata=0.
  - Load: rsp_rdata := stored word, i.e. pre-edge contents.
  - rsp_valid:=1.
- Latency: rsp_valid is first high in the cycle after E0+WAIT_CYCLES, which is WAIT_CYCLES+1 cycles after acceptance.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid:=0, rsp_err:=0, state:=IDLE. rsp_rdata keeps its value.
  - No request is accepted in the handshake cycle; the minimum issue interval is WAIT_CYCLES+2 cycles.
- A store with wstrb=0 is a legal no-op that still returns a response with rsp_err=0.
- Request inputs are ignored outside IDLE. Input changes during WAIT do not affect the latched request.
- Reset mid-operation: a pending request that has not reached its commit edge is dropped, with no storage write and no response. A response pending in RESP is discarded.
- Protocol assertion: a requester must not drop req_valid before req_ready; the responder itself has no dependency on this.

Optional Feature:
- Macro DMEM_RESPONDER_PERF_CNT_EN.
- When defined, adds three outputs, each 32 bits and wrapping modulo 2^32:
  - perf_loads: counts committed loads without error.
  - perf_stores: counts committed stores without error.
  - perf_errs: counts error responses.
- Counters increment at the commit edge and reset to 0.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg:
  - FSM state enum (IDLE/WAIT/RESP).
  - Byte-strobe width constant.
  - Function word_index(addr) returning addr[ADDR_W-1:2].
  - Function is_misaligned(addr).
- One natural sub-module: dmem_array.
  - Synchronous read-before-write word RAM with byte-enable write port and read port, sized DEPTH_WORDS.
  - Keeps storage separable from the FSM/handshake logic in dmem_responder.

Test Plan:
- WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, accepted at cycle 5; rsp_ready=1. Required: rsp_valid high in cycle 8 only, rsp_err=0. Then load addr=0x10 returns rsp_rdata=0xDEADBEEF.
- Byte strobes: word 0x20 holds 0x11223344; store wdata=0xAABBCCDD with wstrb=0x5; load 0x20 -> rsp_rdata=0x11BB33DD.
- Backpressure: rsp_ready held 0 for 6 cycles after rsp_valid. Required: rsp_valid, rsp_rdata and rsp_err stable, and req_ready=0 throughout. The request presented during this window is accepted only in the cycle after the response handshake.
- Errors:
  - Load addr=0x13 -> rsp_err=1, rsp_rdata=0.
  - Store addr=DEPTH_WORDS*4 -> rsp_err=1, with a following load of word DEPTH_WORDS-1 unchanged.
  - With DMEM_RESPONDER_PERF_CNT_EN, perf_errs=2.
- Reset mid-wait: store 0x55 to addr=0x40 accepted, rst=0 asserted one cycle later. Required: immediate rsp_valid=0 and req_ready=0. After release, load 0x40 returns the prior contents.
- WAIT_CYCLES=0: load accepted at edge N -> rsp_valid high in cycle N+1. Back-to-back loads with rsp_ready=1 yield one response every 2 cycles.
